sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Single-clock synchronous FIFO, parametrised successor to the team's fixed 8x16 FIFO. Generalised in width and depth. Adds:
- an occupancy count;
- programmable almost-full and almost-empty flags;
- defined simultaneous read/write at the full and empty boundaries;
- overflow and underflow error reporting.

It is used as the standard buffering element between producer and consumer blocks in the same clock domain.

Parameters:
- FIFO_WIDTH, 8, data word width in bits (>=1).
- FIFO_DEPTH, 16, number of entries; power of two, >=4.
- AFULL_THRESH, FIFO_DEPTH-4, fifo_afull asserted when count >= this value; legal range 1..FIFO_DEPTH.
- AEMPTY_THRESH, 4, fifo_aempty asserted when count <= this value; legal range 0..FIFO_DEPTH-1.
- Derived localparams: PTR_W = $clog2(FIFO_DEPTH), CNT_W = PTR_W+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- wr  input  1  write request.
- rd  input  1  read request.
- data_in  input  FIFO_WIDTH  write data, sampled on an accepted write.
- data_out  output  FIFO_WIDTH  registered read data.
- fifo_full  output  1  count == FIFO_DEPTH.
- fifo_empty  output  1  count == 0.
- fifo_afull  output  1  count >= AFULL_THRESH.
- fifo_aempty  output  1  count <= AEMPTY_THRESH.
- fifo_count  output  CNT_W  current occupancy, 0..FIFO_DEPTH.
- overflow  output  1  write rejected (see Behaviour).
- underflow  output  1  read rejected (see Behaviour).

Behaviour:
- Reset (rst_n low, async): wr_ptr=0, rd_ptr=0, count=0, data_out=0, overflow=0, underflow=0. Resulting outputs: fifo_empty=1, fifo_full=0, fifo_aempty=1, fifo_afull=0. Memory array is not reset; contents are don't-care.
- Accept rules, evaluated on current-cycle state:
  - rd_acc = rd & !fifo_empty.
  - wr_acc = wr & (!fifo_full | rd_acc). A write at full is accepted only when a read is accepted in the same cycle.
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr increments modulo FIFO_DEPTH, natural wrap.
- Accepted read: data_out <= mem[rd_ptr] at the same edge, giving 1-cycle read latency. rd_ptr increments modulo FIFO_DEPTH. data_out holds its value when no read is accepted.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Flags are combinational decodes of the registered count. They never glitch on wr/rd within a cycle.
- Simultaneous wr & rd at empty: the write is accepted and the read rejected (underflow raised). Count goes to 1; data_out is unchanged.
- Simultaneous wr & rd at full: both are accepted. Count stays at FIFO_DEPTH; data_out gets the oldest word; the new word is stored in the freed slot.
- Error flags:
  - overflow is a registered 1-cycle pulse in the cycle after wr & !wr_acc.
  - underflow is a registered 1-cycle pulse in the cycle after rd & !rd_acc.
  - A rejected operation never modifies pointers, count, memory or data_out.
- Reset mid-operation: all state returns to reset values immediately, regardless of pending wr/rd. The first edge after deassertion behaves as if the FIFO is empty.
- Ordering: strict FIFO order across any number of pointer wraps.

Optional Feature:
- Macro: SYNC_FIFO_STICKY_ERR_EN.
- Defined: overflow and underflow are sticky. Once set they stay high until rst_n is asserted. Further error events leave them set, and normal traffic continues unaffected.
- Undefined: overflow and underflow are 1-cycle pulses as described in Behaviour.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F (defaults) -> fifo_afull rises the cycle count reaches 12. fifo_full=1 and fifo_count=16 after the 16th write; fifo_empty falls after the first write; overflow=0 throughout.
- At full, wr with data 0xAA and rd=0 -> overflow pulses 1 cycle (sticky if macro defined); count stays 16; 0xAA never appears on a later drain.
- Drain with 16 back-to-back reads -> data_out = 0x00..0x0F, each one cycle after its rd. fifo_aempty rises at count 4; fifo_empty=1 at the end; a 17th rd gives an underflow pulse and data_out holds 0x0F.
- Fill to 16, then wr=rd=1 for 5 cycles with data 0x20..0x24 -> count stays 16; data_out = 0x00..0x04; a later drain yields 0x05..0x0F then 0x20..0x24.
- Empty FIFO, wr=rd=1 with data 0x55 -> underflow pulse; count=1; data_out unchanged. The next rd returns 0x55.
- Write 10 words, assert rst_n low mid-burst, release, then write 0x77 and read -> count=0 and fifo_empty=1 during reset; data_out=0 after reset; the read returns 0x77 with no stale data.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with count, almost-full/empty flags and overflow/underflow reporting; SYNC_FIFO_STICKY_ERR_EN makes errors sticky.
// Read data is registered (1-cycle latency); writes at full are rejected unless paired with an accepted read.
module sync_fifo_param #(
   parameter int FIFO_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 16,
   parameter int AFULL_THRESH  = FIFO_DEPTH - 4,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr,
   input  logic                        rd,
   input  logic [FIFO_WIDTH-1:0]       data_in,
   output logic [FIFO_WIDTH-1:0]       data_out,
   output logic                        fifo_full,
   output logic                        fifo_empty,
   output logic                        fifo_afull,
   output logic                        fifo_aempty,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [FIFO_WIDTH-1:0] r_data_out;
   logic                  r_overflow;
   logic                  r_underflow;

   logic w_full;
   logic w_empty;
   logic w_rd_acc;
   logic w_wr_acc;
   logic w_ovf_evt;
   logic w_unf_evt;

   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   // A write at full is only safe when a read frees a slot at the same edge.
   assign w_rd_acc  = rd & ~w_empty;
   assign w_wr_acc  = wr & (~w_full | w_rd_acc);
   assign w_ovf_evt = wr & ~w_wr_acc;
   assign w_unf_evt = rd & ~w_rd_acc;

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_data_out  <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
            r_data_out <= r_mem[r_rd_ptr];
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
`ifdef SYNC_FIFO_STICKY_ERR_EN
         r_overflow  <= r_overflow  | w_ovf_evt;
         r_underflow <= r_underflow | w_unf_evt;
`else
         r_overflow  <= w_ovf_evt;
         r_underflow <= w_unf_evt;
`endif
      end
   end

   assign data_out    = r_data_out;
   assign fifo_full   = w_full;
   assign fifo_empty  = w_empty;
   assign fifo_afull  = (r_count >= CNT_W'(AFULL_THRESH));
   assign fifo_aempty = (r_count <= CNT_W'(AEMPTY_THRESH));
   assign fifo_count  = r_count;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboarded bench for sync_fifo_param: queue-based reference model, directed scenarios plus randomized traffic.
module tb_sync_fifo_param;

   localparam int W      = 8;
   localparam int DEPTH  = 16;
   localparam int AFULL  = DEPTH - 4;
   localparam int AEMPTY = 4;

   logic         clk;
   logic         rst_n;
   logic         wr;
   logic         rd;
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;
   logic         fifo_full;
   logic         fifo_empty;
   logic         fifo_afull;
   logic         fifo_aempty;
   logic [4:0]   fifo_count;
   logic         overflow;
   logic         underflow;

   sync_fifo_param #(
      .FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .data_in(data_in),
      .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_afull(fifo_afull), .fifo_aempty(fifo_aempty), .fifo_count(fifo_count),
      .overflow(overflow), .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           edge_no;
      int           cnt;
      logic [W-1:0] dout;
      bit           ovf;
      bit           unf;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] mq[$];
   logic [W-1:0] m_dout;
   bit           m_ovf;
   bit           m_unf;
   int           edge_cnt = 0;
   int           checks   = 0;
   int           errors   = 0;

   always @(posedge clk) edge_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every post-edge DUT state against the queued expectation for that edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            e = sb.pop_front();
            chk("count",     32'(fifo_count),  32'(e.cnt));
            chk("data_out",  32'(data_out),    32'(e.dout));
            chk("overflow",  32'(overflow),    32'(e.ovf));
            chk("underflow", 32'(underflow),   32'(e.unf));
            chk("full",      32'(fifo_full),   32'(e.cnt == DEPTH));
            chk("empty",     32'(fifo_empty),  32'(e.cnt == 0));
            chk("afull",     32'(fifo_afull),  32'(e.cnt >= AFULL));
            chk("aempty",    32'(fifo_aempty), 32'(e.cnt <= AEMPTY));
         end
      end
   end

   task automatic cycle(input bit w, input bit r, input logic [W-1:0] d);
      bit   rd_ok, wr_ok;
      exp_t e;
      wr = w; rd = r; data_in = d;
      rd_ok = r && (mq.size() > 0);
      wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
      if (rd_ok) m_dout = mq.pop_front();
      if (wr_ok) mq.push_back(d);
`ifdef SYNC_FIFO_STICKY_ERR_EN
      m_ovf = m_ovf || (w && !wr_ok);
      m_unf = m_unf || (r && !rd_ok);
`else
      m_ovf = w && !wr_ok;
      m_unf = r && !rd_ok;
`endif
      e.edge_no = edge_cnt + 1;
      e.cnt     = mq.size();
      e.dout    = m_dout;
      e.ovf     = m_ovf;
      e.unf     = m_unf;
      sb.push_back(e);
      @(posedge clk);
      #1;
      wr = 1'b0; rd = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_count"},  32'(fifo_count),  32'd0);
      chk({tag, "_empty"},  32'(fifo_empty),  32'd1);
      chk({tag, "_full"},   32'(fifo_full),   32'd0);
      chk({tag, "_aempty"}, 32'(fifo_aempty), 32'd1);
      chk({tag, "_afull"},  32'(fifo_afull),  32'd0);
      chk({tag, "_dout"},   32'(data_out),    32'd0);
      chk({tag, "_ovf"},    32'(overflow),    32'd0);
      chk({tag, "_unf"},    32'(underflow),   32'd0);
   endtask

   // Asynchronous reset applied mid-cycle while a write is still being requested.
   task automatic mid_reset();
      @(negedge clk);
      #1;
      wr = 1'b1; rd = 1'b1; data_in = 8'hEE;
      rst_n = 1'b0;
      mq.delete();
      m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
      #1;
      check_reset_state("rst_async");
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("rst_held");
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic fill_seq(input int n, input logic [W-1:0] base);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, base + W'(i));
   endtask

   task automatic reads(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, '0);
   endtask

   initial begin
      int p_wr, p_rd;
      wr = 1'b0; rd = 1'b0; data_in = '0;
      m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("init");
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      fill_seq(16, 8'h00);                     // fill, afull at 12, full at 16
      cycle(1'b1, 1'b0, 8'hAA);                // overflow at full
      cycle(1'b0, 1'b0, 8'h00);
      reads(16);                               // drain 00..0F
      cycle(1'b0, 1'b1, 8'h00);                // underflow, data_out holds 0F
      cycle(1'b0, 1'b0, 8'h00);

      mid_reset();                             // clears any sticky flags
      fill_seq(16, 8'h00);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'h20 + 8'(i));
      reads(16);                               // 05..0F then 20..24

      cycle(1'b1, 1'b1, 8'h55);                // write-and-read at empty
      cycle(1'b0, 1'b1, 8'h00);                // returns 55
      cycle(1'b0, 1'b0, 8'h00);

      fill_seq(10, 8'h40);
      mid_reset();
      cycle(1'b1, 1'b0, 8'h77);
      cycle(1'b0, 1'b1, 8'h00);                // must return 77, nothing stale
      cycle(1'b0, 1'b0, 8'h00);

      mid_reset();
      for (int ph = 0; ph < 20; ph++) begin
         p_wr = $urandom_range(15, 85);
         p_rd = $urandom_range(15, 85);
         for (int i = 0; i < 100; i++)
            cycle($urandom_range(0, 99) < p_wr, $urandom_range(0, 99) < p_rd, W'($urandom));
      end
      reads(DEPTH + 1);
      cycle(1'b0, 1'b0, 8'h00);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
